// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: captures a and b, ripples one borrow bit per
// clock LSB-first, and presents a-b with its final borrow for one done cycle.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_next;
   logic [CW-1:0]    cnt;
   logic             bor;
   logic             d;
   logic             bor_next;

   always_comb begin
      d          = a_sh[0] ^ b_sh[0] ^ bor;
      bor_next   = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & bor) | (b_sh[0] & bor);
      res_next   = {d, res[WIDTH-1:1]};
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (cnt == LAST) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // busy/done are registered copies of the next state so they line up with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh       <= '0;
         b_sh       <= '0;
         res        <= '0;
         cnt        <= '0;
         bor        <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         busy <= (state_next == SHIFT);
         done <= (state_next == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh <= a;
                  b_sh <= b;
                  bor  <= 1'b0;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               res  <= res_next;
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               bor  <= bor_next;
               cnt  <= cnt + CW'(1);
               if (cnt == LAST) begin
                  diff       <= res_next;
                  borrow_out <= bor_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: timeline model of the operation
// plus arithmetic reference results, compared on every falling edge.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .a(a),
      .b(b),
      .busy(busy),
      .done(done),
      .diff(diff),
      .borrow_out(borrow_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // model: age = edges since capture (-1 when idle)
   int           age    = -1;
   logic [W-1:0] m_diff = '0;
   logic         m_bor  = 1'b0;
   logic [W-1:0] p_diff = '0;
   logic         p_bor  = 1'b0;

   always @(negedge rst_n) begin
      age    = -1;
      m_diff = '0;
      m_bor  = 1'b0;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         if (age < 0) begin
            if (start) begin
               age    = 0;
               p_diff = W'(int'(a) - int'(b));
               p_bor  = (a < b);
            end
         end else if (age == int'(W)) begin
            age = -1;
         end else begin
            age = age + 1;
            if (age == int'(W)) begin
               m_diff = p_diff;
               m_bor  = p_bor;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("busy", 32'(busy), 32'(age >= 0 && age < int'(W)));
      chk("done", 32'(done), 32'(age == int'(W)));
      chk("diff", 32'(diff), 32'(m_diff));
      chk("borrow_out", 32'(borrow_out), 32'(m_bor));
   end

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit lit,
                         input logic [W-1:0] ed, input logic eb);
      int k;
      @(negedge clk);
      a     = x;
      b     = y;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      k     = 0;
      while (!done && k < int'(W) + 4) begin
         @(negedge clk);
         k++;
      end
      chk("latency", 32'(k), 32'(W));
      if (lit) begin
         chk("lit_diff", 32'(diff), 32'(ed));
         chk("lit_borrow", 32'(borrow_out), 32'(eb));
      end
      @(negedge clk);
   endtask

   initial begin
      int last;
      int pulses;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_borrow", 32'(borrow_out), 32'd0);
      rst_n = 1'b1;

      run_op(8'h5A, 8'h23, 1'b1, 8'h37, 1'b0);
      run_op(8'h00, 8'h01, 1'b1, 8'hFF, 1'b1);
      run_op(8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0);
      run_op(8'h00, 8'hFF, 1'b1, 8'h01, 1'b1);

      // start held high: DONE->IDLE edge ignores start, so one op per W+2 cycles
      @(negedge clk);
      a      = 8'h10;
      b      = 8'h01;
      start  = 1'b1;
      last   = -1;
      pulses = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (done) begin
            chk("hold_diff", 32'(diff), 32'h0F);
            if (last >= 0) chk("hold_period", 32'(i - last), 32'(W + 2));
            last = i;
            pulses++;
         end
      end
      start = 1'b0;
      chk("hold_pulses", 32'(pulses), 32'd4);
      repeat (12) @(negedge clk);

      // reset during the 4th SHIFT cycle
      a     = 8'h80;
      b     = 8'h01;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_diff", 32'(diff), 32'd0);
      chk("abort_borrow", 32'(borrow_out), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b0);

      for (int n = 0; n < 2000; n++) begin
         logic [W-1:0] x;
         logic [W-1:0] y;
         x = W'($urandom);
         y = W'($urandom);
         if (n % 97 == 0) y = x;
         if (n % 89 == 0) x = '0;
         if (n % 83 == 0) y = '1;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_op(x, y, 1'b1, W'(int'(x) - int'(y)), x < y);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
